tmvp_acc: RTL and testbench

Inner-product accumulator that sits directly downstream of the 16-bit adder in the TMVP datapath. It consumes one adder result per accepted beat and sums exactly LEN terms modulo 2^Q_BITS. It then presents the final sum with a one-cycle done pulse. The result is handed to the writeback/VLIW lane for one row of a Toeplitz matrix-vector product.

---
 rtl/tmvp_pkg.sv | 19 +
 rtl/tmvp_acc.sv | 93 +++++++++
 tb/tb_tmvp_acc.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/tmvp_pkg.sv
// Shared definitions for the TMVP accumulator: default widths, the modulus mask
// for the default Q_BITS, and the three-state controller encoding.
package tmvp_pkg;

  localparam int TMVP_WIDTH  = 16;
  localparam int TMVP_Q_BITS = 16;

  // One extra bit so that Q_BITS == WIDTH still yields an all-ones mask.
  localparam logic [TMVP_WIDTH:0] TMVP_Q_MASK_EXT =
    ((TMVP_WIDTH+1)'(1) << TMVP_Q_BITS) - (TMVP_WIDTH+1)'(1);
  localparam logic [TMVP_WIDTH-1:0] TMVP_Q_MASK = TMVP_Q_MASK_EXT[TMVP_WIDTH-1:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tmvp_acc.sv
// Inner-product accumulator: sums LEN adder results modulo 2^Q_BITS and presents
// the final sum on acc_out together with a one-cycle done pulse.
module tmvp_acc
  import tmvp_pkg::*;
#(
  parameter int WIDTH  = TMVP_WIDTH,
  parameter int LEN    = 8,
  parameter int CNT_W  = 4,
  parameter int Q_BITS = TMVP_Q_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [0:WIDTH-1] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] acc_out
);

  // Bit 0 is the MSB, so the Q_BITS field sits at the numerically low end.
  localparam logic [WIDTH:0] MASK_EXT = ((WIDTH+1)'(1) << Q_BITS) - (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MASK = MASK_EXT[WIDTH-1:0];
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  state_e             state_q, state_d;
  logic [0:WIDTH-1]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [0:WIDTH-1]   acc_out_q, acc_out_d;
  logic [0:WIDTH-1]   sum;
  logic               accept;

  assign sum = (acc_q + in_data) & MASK;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    acc_out_d = acc_out_q;
    in_ready  = (state_q == ST_ACC);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    accept    = in_valid && in_ready;

    // Abort wins over start and data; the last completed sum is kept.
    if (clr) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_d   = '0;
            count_d = '0;
            state_d = ST_ACC;
          end
        end
        ST_ACC: begin
          if (accept) begin
            acc_d   = sum;
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST) begin
              acc_out_d = sum;
              state_d   = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      acc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      acc_out_q <= acc_out_d;
    end
  end

  assign acc_out = acc_out_q;

endmodule

// File: tb/tb_tmvp_acc.sv
// Directed bench for tmvp_acc: two LEN=4 instances (Q_BITS=16 and 13) share one
// stimulus stream; table-driven runs plus hand sequences for abort/reset/illegal inputs.
module tb_tmvp_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [0:15] in_data = '0;

  logic        in_ready16, busy16, done16;
  logic [0:15] acc_out16;
  logic        in_ready13, busy13, done13;
  logic [0:15] acc_out13;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt16 = 0;
  int done_cnt13 = 0;

  typedef struct {
    logic [15:0] beats [4];
    int          gap;
    logic [15:0] exp16;
    logic [15:0] exp13;
  } vec_t;

  vec_t vecs [6];

  tmvp_acc #(.WIDTH(16), .LEN(4), .CNT_W(4), .Q_BITS(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready16), .busy(busy16), .done(done16),
    .acc_out(acc_out16)
  );

  tmvp_acc #(.WIDTH(16), .LEN(4), .CNT_W(4), .Q_BITS(13)) dut13 (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready13), .busy(busy13), .done(done13),
    .acc_out(acc_out13)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done16 === 1'b1) done_cnt16++;
    if (done13 === 1'b1) done_cnt13++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag);
    int d16, d13;
    d16 = done_cnt16;
    d13 = done_cnt13;
    start = 1'b1;
    step();
    start = 1'b0;
    check_output({tag, " busy after start"}, 16'(busy16), 16'd1);
    check_output({tag, " in_ready in ACC"}, 16'(in_ready16), 16'd1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = v.beats[i];
      step();
      in_valid = 1'b0;
      if (i < 3) repeat (v.gap) step();
    end
    check_output({tag, " done pulse"}, 16'(done16), 16'd1);
    check_output({tag, " acc_out q16"}, acc_out16, v.exp16);
    check_output({tag, " acc_out q13"}, acc_out13, v.exp13);
    check_output({tag, " q13 upper bits"}, 16'(acc_out13[0:2]), 16'd0);
    check_output({tag, " in_ready in DONE"}, 16'(in_ready16), 16'd0);
    step();
    check_output({tag, " done dropped"}, 16'(done16), 16'd0);
    check_output({tag, " busy dropped"}, 16'(busy16), 16'd0);
    check_output({tag, " one done q16"}, 16'(done_cnt16 - d16), 16'd1);
    check_output({tag, " one done q13"}, 16'(done_cnt13 - d13), 16'd1);
  endtask

  initial begin
    int d16;

    vecs[0].beats = '{16'h0001, 16'h0002, 16'h0003, 16'h0004}; vecs[0].gap = 0;
    vecs[0].exp16 = 16'h000A; vecs[0].exp13 = 16'h000A;
    vecs[1].beats = '{16'hFFFF, 16'h0002, 16'h0000, 16'h0000}; vecs[1].gap = 0;
    vecs[1].exp16 = 16'h0001; vecs[1].exp13 = 16'h0001;
    vecs[2].beats = '{16'h8000, 16'h8000, 16'h8000, 16'h8000}; vecs[2].gap = 0;
    vecs[2].exp16 = 16'h0000; vecs[2].exp13 = 16'h0000;
    vecs[3].beats = '{16'h1FFF, 16'h0001, 16'h0005, 16'h0000}; vecs[3].gap = 0;
    vecs[3].exp16 = 16'h2005; vecs[3].exp13 = 16'h0005;
    vecs[4].beats = '{16'h1234, 16'h1111, 16'h0F0F, 16'h0001}; vecs[4].gap = 1;
    vecs[4].exp16 = 16'h3255; vecs[4].exp13 = 16'h1255;
    vecs[5].beats = '{16'h0001, 16'h0002, 16'h0003, 16'h0004}; vecs[5].gap = 3;
    vecs[5].exp16 = 16'h000A; vecs[5].exp13 = 16'h000A;

    // Reset state, then release and stay idle.
    rst = 1'b1;
    step();
    step();
    check_output("reset acc_out", acc_out16, 16'h0000);
    check_output("reset done", 16'(done16), 16'd0);
    check_output("reset busy", 16'(busy16), 16'd0);
    check_output("reset in_ready", 16'(in_ready16), 16'd0);
    rst = 1'b0;
    step();
    step();
    check_output("idle busy", 16'(busy16), 16'd0);
    check_output("idle in_ready", 16'(in_ready16), 16'd0);

    for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Data while idle and data alongside start must not be consumed; start mid-ACC ignored.
    d16 = done_cnt16;
    in_valid = 1'b1;
    in_data  = 16'h0100;
    step();
    check_output("idle ignores valid", 16'(in_ready16), 16'd0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    in_data = 16'h0001;
    step();
    start = 1'b1;
    in_data = 16'h0002;
    step();
    start = 1'b0;
    in_valid = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    in_valid = 1'b1;
    in_data = 16'h0003;
    step();
    in_data = 16'h0004;
    step();
    in_valid = 1'b0;
    check_output("illegal done pulse", 16'(done16), 16'd1);
    check_output("illegal acc_out", acc_out16, 16'h000A);
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("start in DONE ignored", 16'(busy16), 16'd0);
    check_output("illegal one done", 16'(done_cnt16 - d16), 16'd1);

    // Abort after two beats: clr beats start and data in the same cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    check_output("restart from idle", 16'(busy16), 16'd1);
    d16 = done_cnt16;
    in_valid = 1'b1;
    in_data = 16'h0005;
    step();
    in_data = 16'h0006;
    step();
    clr = 1'b1;
    start = 1'b1;
    in_data = 16'h0007;
    step();
    clr = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    check_output("clr busy", 16'(busy16), 16'd0);
    check_output("clr in_ready", 16'(in_ready16), 16'd0);
    check_output("clr keeps acc_out", acc_out16, 16'h000A);
    repeat (6) step();
    check_output("clr no done", 16'(done_cnt16 - d16), 16'd0);

    // Reset in the middle of an operation clears acc_out too.
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h0005;
    step();
    in_data = 16'h0006;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    check_output("midrst acc_out q16", acc_out16, 16'h0000);
    check_output("midrst acc_out q13", acc_out13, 16'h0000);
    check_output("midrst busy", 16'(busy16), 16'd0);
    repeat (6) step();
    check_output("midrst no done", 16'(done_cnt16 - d16), 16'd0);

    apply_stimulus(vecs[0], "post-reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
